// File: rtl/axis_rx_frame_buffer.sv
// -----------------------------------------------------------------------------
// axis_rx_frame_buffer
//
// Store-and-forward packet FIFO for the receive path. Byte-wide AXI-Stream
// frames are written into a circular RAM. A frame becomes visible to the read
// side only after its last beat arrives without an error flag. Errored frames,
// and frames that do not fit, are discarded by rewinding the write pointer to
// the end of the last good frame. Downstream therefore never sees a partial
// or bad frame.
//
// Parameters
//   DEPTH_LOG2     buffer holds 2**DEPTH_LOG2 bytes
//   CNT_W          width of the saturating frame statistics counters
//
// Ports
//   clk            single clock for all logic
//   rst            asynchronous, active-high reset
//   s_axis_*       ingress stream (tdata/tvalid/tready/tlast/tuser). tready is
//                  1 from the first edge after reset and never drops; tuser
//                  marks a bad frame and is looked at only on the tlast beat.
//   m_axis_*       egress stream (tdata/tvalid/tready/tlast), fully registered
//   good_frames    count of committed frames (saturating)
//   dropped_frames count of discarded frames (saturating)
//   drop_pulse     one-cycle pulse per discarded frame
// -----------------------------------------------------------------------------
module axis_rx_frame_buffer #(
  parameter int DEPTH_LOG2 = 11,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [CNT_W-1:0] good_frames,
  output logic [CNT_W-1:0] dropped_frames,
  output logic             drop_pulse
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam int                PTR_W    = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0]  FULL_LVL = PTR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic {
    ST_WRITE = 1'b0,
    ST_DROP  = 1'b1
  } wr_state_t;

  // Each entry is {tlast, data}.
  logic [8:0]       r_mem [DEPTH];

  wr_state_t        r_state;
  wr_state_t        w_state_next;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_wr_commit;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] w_wr_ptr_next;
  logic [PTR_W-1:0] w_wr_commit_next;
  logic [PTR_W-1:0] w_occupancy;
  logic             w_beat;
  logic             w_full;
  logic             w_mem_we;
  logic             w_good_inc;
  logic             w_drop_inc;
  logic             w_readable;
  logic             w_rd_en;

  logic             r_s_tready;
  logic [7:0]       r_m_tdata;
  logic             r_m_tvalid;
  logic             r_m_tlast;
  logic [CNT_W-1:0] r_good_frames;
  logic [CNT_W-1:0] r_dropped_frames;
  logic             r_drop_pulse;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  assign w_beat      = s_axis_tvalid && r_s_tready;
  // Occupancy counts every byte written, committed or not, against the read
  // pointer as it stood before this cycle's read.
  assign w_occupancy = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_occupancy == FULL_LVL);

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next     = r_state;
    w_wr_ptr_next    = r_wr_ptr;
    w_wr_commit_next = r_wr_commit;
    w_mem_we         = 1'b0;
    w_good_inc       = 1'b0;
    w_drop_inc       = 1'b0;

    case (r_state)
      ST_WRITE: begin
        if (w_beat) begin
          if (w_full) begin
            // No room: throw away what has been stored of this frame. A
            // non-last beat means more of the frame is still coming.
            w_wr_ptr_next = r_wr_commit;
            w_drop_inc    = 1'b1;
            if (!s_axis_tlast) begin
              w_state_next = ST_DROP;
            end
          end else begin
            w_mem_we      = 1'b1;
            w_wr_ptr_next = r_wr_ptr + PTR_ONE;
            if (s_axis_tlast) begin
              if (s_axis_tuser) begin
                w_wr_ptr_next = r_wr_commit;
                w_drop_inc    = 1'b1;
              end else begin
                w_wr_commit_next = r_wr_ptr + PTR_ONE;
                w_good_inc       = 1'b1;
              end
            end
          end
        end
      end

      ST_DROP: begin
        // The frame was already counted as dropped when it overflowed.
        if (w_beat && s_axis_tlast) begin
          w_state_next = ST_WRITE;
        end
      end

      default: w_state_next = ST_WRITE;
    endcase
  end

  // NOTE: the buffer RAM has no reset; stale contents are unreachable because
  // the pointers are reset, and leaving it out lets the array map onto RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_WRITE;
      r_wr_ptr         <= '0;
      r_wr_commit      <= '0;
      r_s_tready       <= 1'b0;
      r_good_frames    <= '0;
      r_dropped_frames <= '0;
      r_drop_pulse     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_wr_ptr     <= w_wr_ptr_next;
      r_wr_commit  <= w_wr_commit_next;
      r_s_tready   <= 1'b1;
      r_drop_pulse <= w_drop_inc;
      if (w_good_inc && (r_good_frames != CNT_MAX)) begin
        r_good_frames <= r_good_frames + CNT_ONE;
      end
      if (w_drop_inc && (r_dropped_frames != CNT_MAX)) begin
        r_dropped_frames <= r_dropped_frames + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: one registered output stage, refilled whenever it is empty or
  // being drained and a committed byte is waiting.
  // ---------------------------------------------------------------------------
  assign w_readable = (r_rd_ptr != r_wr_commit);
  assign w_rd_en    = (!r_m_tvalid || m_axis_tready) && w_readable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else if (w_rd_en) begin
      {r_m_tlast, r_m_tdata} <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
      r_m_tvalid             <= 1'b1;
      r_rd_ptr               <= r_rd_ptr + PTR_ONE;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign s_axis_tready  = r_s_tready;
  assign m_axis_tdata   = r_m_tdata;
  assign m_axis_tvalid  = r_m_tvalid;
  assign m_axis_tlast   = r_m_tlast;
  assign good_frames    = r_good_frames;
  assign dropped_frames = r_dropped_frames;
  assign drop_pulse     = r_drop_pulse;

endmodule

// File: tb/tb_axis_rx_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_axis_rx_frame_buffer
//
// Directed bench for axis_rx_frame_buffer with a 16-byte buffer. Inputs are
// driven 1 ns after each rising edge; outputs are sampled at the same point.
// Every output handshake is captured into rx_q and compared against frames
// the bench builds itself.
// -----------------------------------------------------------------------------
module tb_axis_rx_frame_buffer;

  localparam int DEPTH_LOG2 = 4;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tlast;
  logic             s_axis_tuser;
  logic [7:0]       m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic [CNT_W-1:0] good_frames;
  logic [CNT_W-1:0] dropped_frames;
  logic             drop_pulse;

  int         n_checks   = 0;
  int         n_errors   = 0;
  int         n_drops    = 0;
  bit         toggle_rdy = 1'b0;
  logic [8:0] rx_q[$];

  axis_rx_frame_buffer #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .good_frames   (good_frames),
    .dropped_frames(dropped_frames),
    .drop_pulse    (drop_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: record the output handshake and stall state seen before the
  // edge, then verify/collect after it.
  task automatic cycle();
    logic       pv;
    logic       pr;
    logic [8:0] pbeat;
    pv    = m_axis_tvalid;
    pr    = m_axis_tready;
    pbeat = {m_axis_tlast, m_axis_tdata};
    @(posedge clk);
    #1;
    if (pv && pr) rx_q.push_back(pbeat);
    if (pv && !pr) begin
      check("stall_valid", {31'd0, m_axis_tvalid}, 32'd1);
      check("stall_hold", {23'd0, m_axis_tlast, m_axis_tdata}, {23'd0, pbeat});
    end
    if (drop_pulse) n_drops++;
    if (toggle_rdy) m_axis_tready = ~m_axis_tready;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic user);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    cycle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  // Expected stream: n bytes counting up from base, tlast every fl bytes.
  task automatic check_rx(input string tag, input logic [7:0] base, input int n, input int fl);
    logic [31:0] obs;
    logic [31:0] exp;
    check({tag, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      exp = {23'd0, ((i + 1) % fl == 0), 8'(int'(base) + i)};
      obs = (i < rx_q.size()) ? {23'd0, rx_q[i]} : 32'hDEAD;
      check($sformatf("%s_beat%0d", tag, i), obs, exp);
    end
  endtask

  initial begin
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    m_axis_tready = 1'b1;

    // ---- reset state ----
    repeat (3) cycle();
    check("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    check("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_good", {16'd0, good_frames}, 32'd0);
    check("rst_dropped", {16'd0, dropped_frames}, 32'd0);
    check("rst_drop_pulse", {31'd0, drop_pulse}, 32'd0);
    rst = 1'b0;
    #1;
    check("rel_s_tready_before_edge", {31'd0, s_axis_tready}, 32'd0);
    cycle();
    check("rel_s_tready", {31'd0, s_axis_tready}, 32'd1);

    // ---- 1: good 5-byte frame ----
    rx_q.delete();
    for (int i = 1; i <= 5; i++) send_beat(8'(i), (i == 5), 1'b0);
    check("t1_idle_at_last", {31'd0, m_axis_tvalid}, 32'd0);
    check("t1_good", {16'd0, good_frames}, 32'd1);
    cycle();
    check("t1_first_valid", {31'd0, m_axis_tvalid}, 32'd1);
    check("t1_first_data", {24'd0, m_axis_tdata}, 32'h01);
    repeat (5) cycle();
    check("t1_back_to_back", rx_q.size(), 32'd5);
    check("t1_idle_after", {31'd0, m_axis_tvalid}, 32'd0);
    check_rx("t1", 8'h01, 5, 5);

    // ---- 2: errored frame then good frame ----
    rx_q.delete();
    n_drops = 0;
    for (int i = 0; i < 4; i++) send_beat(8'(8'h11 + i), (i == 3), (i == 3));
    check("t2_drop_pulse", {31'd0, drop_pulse}, 32'd1);
    check("t2_dropped", {16'd0, dropped_frames}, 32'd1);
    for (int i = 0; i < 3; i++) send_beat(8'(8'hA0 + i), (i == 2), 1'b0);
    check("t2_no_leak", {31'd0, m_axis_tvalid}, 32'd0);
    repeat (8) cycle();
    check("t2_pulse_cycles", n_drops, 32'd1);
    check_rx("t2", 8'hA0, 3, 3);
    check("t2_good", {16'd0, good_frames}, 32'd2);

    // ---- 3: overflow with the sink stalled ----
    // The output stage pulls one byte of the first frame, freeing a slot, so
    // the second frame runs out of room partway through and is dropped.
    rx_q.delete();
    n_drops       = 0;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) send_beat(8'(8'h30 + i), (i == 9), 1'b0);
    for (int i = 0; i < 10; i++) send_beat(8'(8'h40 + i), (i == 9), 1'b0);
    repeat (2) cycle();
    check("t3_dropped", {16'd0, dropped_frames}, 32'd2);
    check("t3_pulse_cycles", n_drops, 32'd1);
    check("t3_good", {16'd0, good_frames}, 32'd3);
    check("t3_held_valid", {31'd0, m_axis_tvalid}, 32'd1);
    check("t3_held_data", {24'd0, m_axis_tdata}, 32'h30);
    m_axis_tready = 1'b1;
    repeat (14) cycle();
    check_rx("t3", 8'h30, 10, 10);

    // ---- 4: backpressure, tready toggling every cycle ----
    rx_q.delete();
    toggle_rdy = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(8'(8'h50 + i), (i == 7), 1'b0);
    repeat (24) cycle();
    toggle_rdy    = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) cycle();
    check_rx("t4", 8'h50, 8, 8);
    check("t4_good", {16'd0, good_frames}, 32'd4);

    // ---- 5: 20 x 7-byte frames across pointer wrap ----
    rx_q.delete();
    for (int f = 0; f < 20; f++) begin
      for (int b = 0; b < 7; b++) send_beat(8'(f * 7 + b), (b == 6), 1'b0);
    end
    repeat (10) cycle();
    check_rx("t5", 8'h00, 140, 7);
    // 4 frames from earlier scenarios plus these 20.
    check("t5_good", {16'd0, good_frames}, 32'd24);
    check("t5_dropped", {16'd0, dropped_frames}, 32'd2);

    // ---- 6: reset in the middle of a frame ----
    rx_q.delete();
    for (int i = 0; i < 3; i++) send_beat(8'(8'h70 + i), 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("t6_s_tready", {31'd0, s_axis_tready}, 32'd0);
    check("t6_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("t6_m_tdata", {24'd0, m_axis_tdata}, 32'd0);
    check("t6_m_tlast", {31'd0, m_axis_tlast}, 32'd0);
    check("t6_good", {16'd0, good_frames}, 32'd0);
    check("t6_dropped", {16'd0, dropped_frames}, 32'd0);
    check("t6_drop_pulse", {31'd0, drop_pulse}, 32'd0);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    check("t6_rel_s_tready", {31'd0, s_axis_tready}, 32'd1);
    rx_q.delete();
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'h62, 1'b1, 1'b0);
    repeat (6) cycle();
    check_rx("t6", 8'h61, 2, 2);
    check("t6_good_after", {16'd0, good_frames}, 32'd1);
    check("t6_dropped_after", {16'd0, dropped_frames}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
